// File: rtl/mem_stall_ctrl.sv
// rtl/mem_stall_ctrl.sv - per-channel memory strobe/done handshake with timeout watchdogs,
// merged pipeline stall, stage/PC enable gating and single-step debug control.
module mem_stall_ctrl #(
   parameter int NCH    = 3,
   parameter int NSTG   = 4,
   parameter int TOUT_W = 8,
   parameter int TOUT   = 200
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [NCH-1:0]  i_req,
   input  logic [NCH-1:0]  i_done,
   input  logic [NSTG-1:0] i_en_in,
   input  logic            i_pc_en_in,
   input  logic            i_step_mode,
   input  logic            i_step_req,
   input  logic            i_err_clr,
   output logic [NCH-1:0]  o_strb,
   output logic [NCH-1:0]  o_busy,
   output logic [NCH-1:0]  o_timeout,
   output logic [NSTG-1:0] o_en_out,
   output logic            o_pc_en_out,
   output logic            o_step_ack
);

   localparam logic [1:0] CH_IDLE   = 2'd0;
   localparam logic [1:0] CH_ACTIVE = 2'd1;
   localparam logic [1:0] CH_DONE   = 2'd2;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_GRANT  = 2'd2;

   // The last ACTIVE cycle is the one whose count is TOUT-1, so an abort
   // happens after exactly TOUT cycles with the strobe high.
   localparam logic [TOUT_W-1:0] CNT_LAST = TOUT_W'(TOUT - 1);
   localparam logic [TOUT_W-1:0] CNT_MAX  = {TOUT_W{1'b1}};
   localparam logic [TOUT_W-1:0] CNT_ONE  = TOUT_W'(1);

   logic [NCH-1:0] w_ch_stall;
   logic           w_stall;
   logic           w_gate;
   logic           w_open;
   logic           w_advance;
   logic [1:0]     r_step_state;
   logic           r_step_ack;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [1:0]        r_state;
      logic [TOUT_W-1:0] r_cnt;
      logic              r_strb;
      logic              r_timeout;
      logic              w_expire;

      assign w_expire      = (r_state == CH_ACTIVE) && !i_done[g] && (r_cnt == CNT_LAST);
      assign w_ch_stall[g] = ((r_state == CH_IDLE) && i_req[g]) ||
                             ((r_state == CH_ACTIVE) && !i_done[g]);
      assign o_strb[g]     = r_strb;
      assign o_busy[g]     = (r_state == CH_ACTIVE);
      assign o_timeout[g]  = r_timeout;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_state   <= CH_IDLE;
            r_cnt     <= '0;
            r_strb    <= 1'b0;
            r_timeout <= 1'b0;
         end else begin
            r_timeout <= w_expire | (r_timeout & ~i_err_clr);
            case (r_state)
               CH_IDLE: begin
                  if (i_req[g]) begin
                     r_state <= CH_ACTIVE;
                     r_strb  <= 1'b1;
                     r_cnt   <= '0;
                  end
               end
               CH_ACTIVE: begin
                  if (i_done[g] || w_expire) begin
                     r_state <= CH_DONE;
                     r_strb  <= 1'b0;
                  end else if (r_cnt != CNT_MAX) begin
                     r_cnt <= r_cnt + CNT_ONE;
                  end
               end
               default: begin
                  r_state <= CH_IDLE;
                  r_strb  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign w_stall     = |w_ch_stall;
   assign w_gate      = (r_step_state != ST_WAIT);
   assign w_advance   = !w_stall && i_pc_en_in && w_gate;
   assign w_open      = i_rst_n && !w_stall && w_gate;
   assign o_en_out    = i_en_in & {NSTG{w_open}};
   assign o_pc_en_out = i_pc_en_in & w_open;
   assign o_step_ack  = r_step_ack;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_step_state <= ST_RUN;
         r_step_ack   <= 1'b0;
      end else begin
         r_step_ack <= 1'b0;
         case (r_step_state)
            ST_RUN: begin
               if (i_step_mode) r_step_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!i_step_mode)    r_step_state <= ST_RUN;
               else if (i_step_req) r_step_state <= ST_GRANT;
            end
            ST_GRANT: begin
               if (w_advance) begin
                  r_step_ack   <= 1'b1;
                  r_step_state <= i_step_mode ? ST_WAIT : ST_RUN;
               end else if (!i_step_mode) begin
                  r_step_state <= ST_RUN;
               end
            end
            default: r_step_state <= ST_RUN;
         endcase
      end
   end

endmodule
